// File: rtl/m72_pkg.sv
// Shared types and defaults for the board B layer mixer: layer priority classes,
// the 5:5:5 palette word layout and the default palette geometry.
package m72_pkg;

  localparam int         PAL_AW_DEF   = 9;
  localparam int         COLOR_W_DEF  = 5;
  localparam logic [8:0] BACKDROP_DEF = 9'h0FF;

  typedef enum logic [2:0] {
    PRI_A_HI,
    PRI_D_HI,
    PRI_OBJ,
    PRI_A_LO,
    PRI_D_LO,
    PRI_BACK
  } pri_e;

  // Palette word as stored in RAM: {B,G,R}, red in the low bits.
  typedef struct packed {
    logic [4:0] b;
    logic [4:0] g;
    logic [4:0] r;
  } rgb555_t;

endpackage

// File: rtl/dpramv.sv
// Dual-port palette RAM: port A is the CPU read/write port, port B the video read port.
// Both ports read-before-write, so a same-edge write is seen only by later reads.
module dpramv #(
  parameter int width_a   = 15,
  parameter int widthad_a = 9
) (
  input  logic                 clock,
  input  logic                 wren_a,
  input  logic                 rden_a,
  input  logic [widthad_a-1:0] address_a,
  input  logic [width_a-1:0]   data_a,
  output logic [width_a-1:0]   q_a,
  input  logic                 rden_b,
  input  logic [widthad_a-1:0] address_b,
  output logic [width_a-1:0]   q_b
);

  logic [width_a-1:0] mem [2**widthad_a];

  always_ff @(posedge clock) begin
    if (rden_a) q_a <= mem[address_a];
    if (rden_b) q_b <= mem[address_b];
    if (wren_a) mem[address_a] <= data_a;
  end

endmodule

// File: rtl/layer_priority_resolve.sv
// Combinational per-pixel priority between tile layers A/D, sprites and backdrop.
// Produces the winning priority class and its palette index.
module layer_priority_resolve
  import m72_pkg::*;
#(
  parameter int         PAL_AW   = PAL_AW_DEF,
  parameter logic [8:0] BACKDROP = BACKDROP_DEF
) (
  input  logic [3:0]        a_bit_i,
  input  logic [3:0]        a_col_i,
  input  logic              a_cp15_i,
  input  logic              a_cp8_i,
  input  logic [3:0]        d_bit_i,
  input  logic [3:0]        d_col_i,
  input  logic              d_cp15_i,
  input  logic              d_cp8_i,
  input  logic [7:0]        obj_pix_i,
  input  logic [2:0]        en_mask_i,
  output pri_e              pri_o,
  output logic [PAL_AW-1:0] idx_o
);

  logic       a_opq, d_opq, o_opq;
  logic       a_hi, d_hi;
  logic [8:0] idx9;

  assign a_opq = en_mask_i[0] && (a_bit_i != 4'h0);
  assign d_opq = en_mask_i[1] && (d_bit_i != 4'h0);
  assign o_opq = en_mask_i[2] && (obj_pix_i[3:0] != 4'h0);
  assign a_hi  = a_cp15_i | (a_cp8_i & a_bit_i[3]);
  assign d_hi  = d_cp15_i | (d_cp8_i & d_bit_i[3]);

  // Front-to-back: high tiles cover sprites, sprites cover low tiles.
  always_comb begin
    pri_o = PRI_BACK;
    idx9  = BACKDROP;
    if (a_opq && a_hi) begin
      pri_o = PRI_A_HI;
      idx9  = {1'b1, a_col_i, a_bit_i};
    end else if (d_opq && d_hi) begin
      pri_o = PRI_D_HI;
      idx9  = {1'b1, d_col_i, d_bit_i};
    end else if (o_opq) begin
      pri_o = PRI_OBJ;
      idx9  = {1'b0, obj_pix_i};
    end else if (a_opq) begin
      pri_o = PRI_A_LO;
      idx9  = {1'b1, a_col_i, a_bit_i};
    end else if (d_opq) begin
      pri_o = PRI_D_LO;
      idx9  = {1'b1, d_col_i, d_bit_i};
    end
  end

  assign idx_o = PAL_AW'(idx9);

endmodule

// File: rtl/board_b_layer_mixer.sv
// Board B layer mixer: three CE_PIX-gated stages (resolve, palette read, RGB out)
// plus a CPU palette port that runs every CLK_32M cycle.
module board_b_layer_mixer
  import m72_pkg::*;
#(
  parameter int         PAL_AW   = PAL_AW_DEF,
  parameter int         COLOR_W  = COLOR_W_DEF,
  parameter logic [8:0] BACKDROP = BACKDROP_DEF
) (
  input  logic               CLK_32M,
  input  logic               reset_n,
  input  logic               CE_PIX,
  input  logic [3:0]         A_BIT,
  input  logic [3:0]         A_COL,
  input  logic               A_CP15,
  input  logic               A_CP8,
  input  logic [3:0]         D_BIT,
  input  logic [3:0]         D_COL,
  input  logic               D_CP15,
  input  logic               D_CP8,
  input  logic [7:0]         OBJ_PIX,
  input  logic               HBLANK,
  input  logic               VBLANK,
  input  logic [2:0]         en_mask,
  input  logic [15:0]        DIN,
  output logic [15:0]        DOUT,
  input  logic [PAL_AW-1:0]  A,
  input  logic               WR,
  input  logic               RD,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B,
  output logic               HB_O,
  output logic               VB_O
);

  pri_e              pri_res;
  logic [PAL_AW-1:0] idx_res;
  logic [PAL_AW-1:0] idx_p1_q;
  logic              hb_p1_q, vb_p1_q, vld_p1_q;
  logic              hb_p2_q, vb_p2_q, vld_p2_q;
  logic [14:0]       pal_cpu, pal_vid;
  rgb555_t           pix_d;
  logic [COLOR_W-1:0] r_q, g_q, b_q;
  logic              hb_o_q, vb_o_q;
  logic              rd_seen_q;
  logic              unused_bits;

  layer_priority_resolve #(
    .PAL_AW   (PAL_AW),
    .BACKDROP (BACKDROP)
  ) u_resolve (
    .a_bit_i   (A_BIT),
    .a_col_i   (A_COL),
    .a_cp15_i  (A_CP15),
    .a_cp8_i   (A_CP8),
    .d_bit_i   (D_BIT),
    .d_col_i   (D_COL),
    .d_cp15_i  (D_CP15),
    .d_cp8_i   (D_CP8),
    .obj_pix_i (OBJ_PIX),
    .en_mask_i (en_mask),
    .pri_o     (pri_res),
    .idx_o     (idx_res)
  );

  dpramv #(
    .width_a   (15),
    .widthad_a (PAL_AW)
  ) u_palette (
    .clock     (CLK_32M),
    .wren_a    (WR),
    .rden_a    (RD),
    .address_a (A),
    .data_a    (DIN[14:0]),
    .q_a       (pal_cpu),
    .rden_b    (CE_PIX),
    .address_b (idx_p1_q),
    .q_b       (pal_vid)
  );

  // Invalid (post-reset) or blanked pixels are forced to black.
  always_comb begin
    pix_d = rgb555_t'(pal_vid);
    if (!vld_p2_q || hb_p2_q || vb_p2_q) pix_d = '0;
  end

  always_ff @(posedge CLK_32M) begin
    if (!reset_n) begin
      idx_p1_q <= '0;
      hb_p1_q  <= 1'b1;
      vb_p1_q  <= 1'b1;
      vld_p1_q <= 1'b0;
      hb_p2_q  <= 1'b1;
      vb_p2_q  <= 1'b1;
      vld_p2_q <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      hb_o_q   <= 1'b1;
      vb_o_q   <= 1'b1;
    end else if (CE_PIX) begin
      // S1: resolved index and blanking captured
      idx_p1_q <= idx_res;
      hb_p1_q  <= HBLANK;
      vb_p1_q  <= VBLANK;
      vld_p1_q <= 1'b1;
      // S2: palette port B reads idx_p1_q on this same enable
      hb_p2_q  <= hb_p1_q;
      vb_p2_q  <= vb_p1_q;
      vld_p2_q <= vld_p1_q;
      // S3: registered colour and blanking outputs
      r_q      <= COLOR_W'(pix_d.r);
      g_q      <= COLOR_W'(pix_d.g);
      b_q      <= COLOR_W'(pix_d.b);
      hb_o_q   <= hb_p2_q;
      vb_o_q   <= vb_p2_q;
    end
  end

  // DOUT stays zero until the first CPU read after reset; RAM output itself has no reset.
  always_ff @(posedge CLK_32M) begin
    if (!reset_n)  rd_seen_q <= 1'b0;
    else if (RD)   rd_seen_q <= 1'b1;
  end

  assign DOUT = rd_seen_q ? {1'b0, pal_cpu} : 16'h0000;
  assign R    = r_q;
  assign G    = g_q;
  assign B    = b_q;
  assign HB_O = hb_o_q;
  assign VB_O = vb_o_q;

  assign unused_bits = ^{pri_res, DIN[15]};

endmodule
